// File: rtl/pipeline_control_unit_if.sv
// Bundle between the Decode-stage decoder / datapath and the pipeline control unit.
// The master drives decoder fields and ALU flags; the slave returns pipeline controls.
interface pipeline_control_unit_if;
  logic       PCSD;
  logic       RegWD;
  logic       MemWD;
  logic       MemtoRegD;
  logic       ALUSrcD;
  logic       BranchD;
  logic       NoWriteD;
  logic [1:0] FlagWD;
  logic [3:0] ALUControlD;
  logic [3:0] CondD;
  logic [3:0] RA1D;
  logic [3:0] RA2D;
  logic [3:0] WA3D;
  logic [3:0] ALUFlags;

  logic [3:0] ALUControlE;
  logic       ALUSrcE;
  logic       BranchTakenE;
  logic       MemWriteM;
  logic       MemtoRegW;
  logic       RegWriteW;
  logic       PCSrcW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic [3:0] Flags;

  modport master (
    output PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, NoWriteD, FlagWD,
           ALUControlD, CondD, RA1D, RA2D, WA3D, ALUFlags,
    input  ALUControlE, ALUSrcE, BranchTakenE, MemWriteM, MemtoRegW, RegWriteW,
           PCSrcW, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, Flags
  );

  modport slave (
    input  PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD, NoWriteD, FlagWD,
           ALUControlD, CondD, RA1D, RA2D, WA3D, ALUFlags,
    output ALUControlE, ALUSrcE, BranchTakenE, MemWriteM, MemtoRegW, RegWriteW,
           PCSrcW, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, Flags
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// Control sequencer for a 5-stage ARM pipeline: E/M/W control registers, NZCV flags,
// condition evaluation, operand forwarding selects and hazard stall/flush generation.
module pipeline_control_unit #(
  parameter bit         FWD_EN     = 1'b1,
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input logic                    clk,
  input logic                    reset,
  pipeline_control_unit_if.slave bus
);

  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic [1:0] flagw;
    logic [3:0] aluctl;
    logic [3:0] cond;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
  } de_t;

  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic [3:0] wa3;
  } em_t;

  typedef struct packed {
    logic       pcs;
    logic       regw;
    logic       memtoreg;
    logic [3:0] wa3;
  } mw_t;

  de_t        de_q, de_d;
  em_t        em_q, em_d;
  mw_t        mw_q, mw_d;
  logic [3:0] flags_q, flags_d;

  logic cond_ex;
  logic branch_taken;
  logic hit_e, hit_m, hit_w;
  logic ldr_stall;
  logic pc_wr_pending;
  logic flush_e;
  logic n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (de_q.cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = ~z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = ~c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = ~n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = ~v;
      4'h8: cond_ex = c & ~z;
      4'h9: cond_ex = ~c | z;
      4'hA: cond_ex = (n == v);
      4'hB: cond_ex = (n != v);
      4'hC: cond_ex = ~z & (n == v);
      4'hD: cond_ex = z | (n != v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign branch_taken = de_q.branch & cond_ex;

  // M result is newer than W, so it wins when both target the same register.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input em_t m, input mw_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (m.regw && ra == m.wa3)      sel = 2'b10;
    else if (w.regw && ra == w.wa3) sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    hit_e = (bus.RA1D == de_q.wa3) | (bus.RA2D == de_q.wa3);
    hit_m = (bus.RA1D == em_q.wa3) | (bus.RA2D == em_q.wa3);
    hit_w = (bus.RA1D == mw_q.wa3) | (bus.RA2D == mw_q.wa3);
  end

  // Without forwarding every pending register write in E/M/W blocks a dependent read.
  assign ldr_stall = (de_q.memtoreg & de_q.regw & hit_e)
                   | (~FWD_EN & ((de_q.regw & hit_e) | (em_q.regw & hit_m) | (mw_q.regw & hit_w)));

  assign pc_wr_pending = bus.PCSD | de_q.pcs | em_q.pcs;
  assign flush_e       = ldr_stall | branch_taken;

  always_comb begin
    de_d = '0;
    if (!flush_e) begin
      de_d.pcs      = bus.PCSD;
      de_d.regw     = bus.RegWD & ~bus.NoWriteD;
      de_d.memw     = bus.MemWD;
      de_d.memtoreg = bus.MemtoRegD;
      de_d.alusrc   = bus.ALUSrcD;
      de_d.branch   = bus.BranchD;
      de_d.flagw    = bus.FlagWD;
      de_d.aluctl   = bus.ALUControlD;
      de_d.cond     = bus.CondD;
      de_d.ra1      = bus.RA1D;
      de_d.ra2      = bus.RA2D;
      de_d.wa3      = bus.WA3D;
    end
  end

  always_comb begin
    em_d          = '0;
    em_d.pcs      = de_q.pcs  & cond_ex;
    em_d.regw     = de_q.regw & cond_ex;
    em_d.memw     = de_q.memw & cond_ex;
    em_d.memtoreg = de_q.memtoreg;
    em_d.wa3      = de_q.wa3;
  end

  always_comb begin
    mw_d          = '0;
    mw_d.pcs      = em_q.pcs;
    mw_d.regw     = em_q.regw;
    mw_d.memtoreg = em_q.memtoreg;
    mw_d.wa3      = em_q.wa3;
  end

  always_comb begin
    flags_d = flags_q;
    if (de_q.flagw[1] && cond_ex) flags_d[3:2] = bus.ALUFlags[3:2];
    if (de_q.flagw[0] && cond_ex) flags_d[1:0] = bus.ALUFlags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q    <= '0;
      em_q    <= '0;
      mw_q    <= '0;
      flags_q <= FLAG_RESET;
    end else begin
      de_q    <= de_d;
      em_q    <= em_d;
      mw_q    <= mw_d;
      flags_q <= flags_d;
    end
  end

  assign bus.ALUControlE  = de_q.aluctl;
  assign bus.ALUSrcE      = de_q.alusrc;
  assign bus.BranchTakenE = branch_taken;
  assign bus.MemWriteM    = em_q.memw;
  assign bus.MemtoRegW    = mw_q.memtoreg;
  assign bus.RegWriteW    = mw_q.regw;
  assign bus.PCSrcW       = mw_q.pcs;
  assign bus.ForwardAE    = FWD_EN ? fwd_sel(de_q.ra1, em_q, mw_q) : 2'b00;
  assign bus.ForwardBE    = FWD_EN ? fwd_sel(de_q.ra2, em_q, mw_q) : 2'b00;
  assign bus.StallF       = ldr_stall | pc_wr_pending;
  assign bus.StallD       = ldr_stall;
  assign bus.FlushD       = pc_wr_pending | mw_q.pcs | branch_taken;
  assign bus.FlushE       = flush_e;
  assign bus.Flags        = flags_q;

endmodule
